// File: rtl/row_fill_scheduler.sv
// Row fill scheduler: runs the pixel generator once per row into a two-bank
// ping-pong line buffer and presents completed banks to the scanout in order.
module row_fill_scheduler #(
  parameter int ROW_COUNT  = 32,
  parameter int FRAME_BITS = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  run,
  output logic                  gen_start,
  output logic [4:0]            gen_y,
  output logic [FRAME_BITS-1:0] gen_frame_count,
  output logic                  gen_bank,
  input  logic                  gen_idle,
  output logic                  scan_valid,
  output logic                  scan_bank,
  output logic [4:0]            scan_y,
  input  logic                  scan_release,
  output logic                  frame_done,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, DONE} state_t;

  state_t                state, state_next;
  logic                  wptr, rptr;
  logic [1:0]            bank_full, bank_full_next;
  logic [4:0]            row_tag [2];
  logic [4:0]            y_cnt;
  logic [FRAME_BITS-1:0] frame_cnt;
  logic                  last_row;
  logic                  release_ok;

  assign last_row   = (y_cnt == 5'(ROW_COUNT - 1));
  assign release_ok = scan_release && bank_full[rptr];

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    gen_start  = 1'b0;
    frame_done = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (run && !bank_full[wptr]) state_next = ISSUE;
      end
      ISSUE: begin
        gen_start  = 1'b1;
        state_next = WAIT_ACK;
      end
      WAIT_ACK:  if (!gen_idle) state_next = WAIT_DONE;
      WAIT_DONE: if (gen_idle)  state_next = DONE;
      DONE: begin
        frame_done = last_row;
        state_next = IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // DONE only ever fills a bank that was empty at ISSUE, so a qualified
  // release in the same cycle always targets the other bank.
  always_comb begin
    bank_full_next = bank_full;
    if (release_ok)      bank_full_next[rptr] = 1'b0;
    if (state == DONE)   bank_full_next[wptr] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr       <= 1'b0;
      rptr       <= 1'b0;
      bank_full  <= '0;
      y_cnt      <= '0;
      frame_cnt  <= '0;
      row_tag[0] <= '0;
      row_tag[1] <= '0;
    end else begin
      bank_full <= bank_full_next;
      if (release_ok) rptr <= ~rptr;
      if (state == DONE) begin
        row_tag[wptr] <= y_cnt;
        wptr          <= ~wptr;
        if (last_row) begin
          y_cnt     <= '0;
          frame_cnt <= frame_cnt + FRAME_BITS'(1);
        end else begin
          y_cnt <= y_cnt + 5'd1;
        end
      end
    end
  end

  assign gen_y           = y_cnt;
  assign gen_frame_count = frame_cnt;
  assign gen_bank        = wptr;
  assign scan_valid      = bank_full[rptr];
  assign scan_bank       = rptr;
  assign scan_y          = row_tag[rptr];

endmodule

// File: doc/row_fill_scheduler.md
Name: row_fill_scheduler

Overview:
Sequences the pixel generator row by row into a two-bank ping-pong line buffer, and hands filled banks to the HUB-75 scanout.
- Producer side: issues one generator start per row, supplying row index, frame count and target bank; completion is the generator's idle flag returning high.
- Consumer side: presents filled banks in order; scanout releases each bank after shifting it out.
- Sits between the frame timing logic, the pixel generator and the row scanout.

Parameters:
ROW_COUNT, 32, rows per frame; y runs 0..ROW_COUNT-1 (max 32, y is 5 bits).
FRAME_BITS, 10, width of the frame counter.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
run  input  1  level; enables filling of new rows
gen_start  output  1  one-cycle start pulse to pixel generator
gen_y  output  5  row index for current fill
gen_frame_count  output  FRAME_BITS  frame number for current fill
gen_bank  output  1  line-buffer bank (write_address bit 6) for current fill
gen_idle  input  1  generator idle flag (low while writing)
scan_valid  output  1  bank at read pointer holds a complete row
scan_bank  output  1  bank to read
scan_y  output  5  row index stored in scan_bank
scan_release  input  1  one-cycle pulse: scanout finished with scan_bank
frame_done  output  1  one-cycle pulse when the last row of a frame finishes filling
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; write pointer 0, read pointer 0, bank_full[1:0]=0; y counter 0; frame counter 0.
  - Reset mid-fill aborts immediately; no gen_start is issued in the cycle after reset.
- State machine:
  - IDLE: if run=1 and bank_full[wptr]=0, go to ISSUE; otherwise stay.
  - ISSUE: gen_start=1 for exactly this cycle. gen_y, gen_frame_count and gen_bank are valid and are held stable until DONE. Go to WAIT_ACK.
  - WAIT_ACK: wait for gen_idle=0, then go to WAIT_DONE. The generator drops idle one cycle after start.
  - WAIT_DONE: wait for gen_idle=1, then go to DONE.
  - DONE (1 cycle):
    - Set bank_full[wptr]=1, record the row in row_tag[wptr]=y, toggle wptr.
    - If y=ROW_COUNT-1: y←0, frame counter +1 (wraps 2^FRAME_BITS-1→0), frame_done=1 this cycle. Otherwise y←y+1.
    - Then go to IDLE.
- Minimum cadence: ISSUE→DONE takes 4 cycles plus the generator run (64 cycles for a 64-pixel row). IDLE→ISSUE adds 1 cycle.
- run=0 never aborts a fill in progress. The current row completes, then the block parks in IDLE with y and frame count preserved; run=1 resumes at the next row.
- Full: if bank_full[wptr]=1 (both banks full), stay in IDLE with gen_start=0 until a release frees that bank.
- Consumer side:
  - scan_valid=bank_full[rptr], scan_bank=rptr, scan_y=row_tag[rptr], all registered.
  - scan_release with scan_valid=1: clear bank_full[rptr], toggle rptr. Visible on scan_valid the next cycle.
  - scan_release with scan_valid=0: ignored, no state change.
- Simultaneous DONE and release: both take effect in the same cycle. They necessarily target different banks when both banks are in use. If the release targets the bank that DONE is setting (only possible with the buffer empty, where scan_valid=0), the release is ignored per the rule above.
- Ordering: rows are presented to scanout in strictly increasing y, wrapping per frame; no row is skipped or duplicated.
- gen_idle is sampled only in WAIT_ACK and WAIT_DONE; changes in other states are ignored.
- busy=1 in ISSUE, WAIT_ACK, WAIT_DONE and DONE.

Test Plan:
- Reset, run=1, generator model with 64-cycle run, scan_release 2 cycles after each scan_valid. Expect: gen_start pulses with gen_y=0,1,2…31 then 0; gen_bank alternating 0,1,0…; frame_done once per 32 rows; gen_frame_count 0→1 at the row-31 DONE.
- No scan_release. Expect: exactly two fills (y=0 bank0, y=1 bank1), then gen_start stays 0. scan_valid=1, scan_bank=0, scan_y=0. One release, then scan_bank=1, scan_y=1, and the third gen_start (y=2, bank0) follows within 2 cycles.
- Drop run during WAIT_DONE of y=5. Expect: y=5 completes and its bank is marked full, no further gen_start. Re-assert run: next gen_start has gen_y=6 and the same frame count.
- scan_release pulsed with scan_valid=0 after reset. Expect: no pointer change; the first filled row still appears on bank 0 with scan_y=0.
- Force the frame counter to 1023 and complete row 31. Expect: frame_done=1, gen_frame_count=0 on the next fill.
- Assert reset in WAIT_DONE with one bank full. Expect: the next cycle has all outputs 0 and scan_valid=0; after release of reset, the first fill is y=0, bank 0, frame 0.
